uart_tx_engine: RTL and testbench

//   Parametrised UART transmitter running directly on the system clock: internal

---
 rtl/uart_tx_engine.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmitter with internal baud divider and valid/ready transmit FIFO; optional parity via UART_TX_PARITY_EN.
// Latency: word accepted at edge N into an idle, empty engine is popped at N+1; uart_tx goes low after N+2.
// Backpressure: tx_ready = !full from the registered count; a push while full is dropped even if a pop happens.

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_vld,
    output logic                     wr_rdy,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_dat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign wr_rdy = (count != FULL_CNT);
    assign empty  = (count == '0);
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_en && !empty;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end
endmodule

module uart_tx_engine #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef UART_TX_PARITY_EN
    ,
    input  logic                          parity_odd
`endif
);
    localparam int DIVISOR = CLK_HZ / BAUD;
    localparam int CW      = $clog2(DIVISOR);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state;
    logic [CW-1:0]        baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] head;
    logic                 fifo_empty;
    logic                 pop;
    logic                 baud_wrap;
    logic                 data_last;
    logic                 stop_last;
    logic                 line_nxt;
`ifdef UART_TX_PARITY_EN
    logic                 par_bit;
`endif

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (tx_valid),
        .wr_rdy (tx_ready),
        .wr_dat (tx_data),
        .rd_en  (pop),
        .rd_dat (head),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign baud_wrap = (baud_cnt == CW'(DIVISOR - 1));
    assign data_last = (bit_cnt == 3'(DATA_BITS - 1));
    assign stop_last = (bit_cnt == 3'(STOP_BITS - 1));
    assign busy      = (state != S_IDLE) || !fifo_empty;

    // The pop on the last stop tick is what makes back-to-back frames gapless.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state == S_IDLE)
                pop = 1'b1;
            else if (state == S_STOP && baud_wrap && stop_last)
                pop = 1'b1;
        end
    end

    always_comb begin
        line_nxt = 1'b1;
        case (state)
            S_START:  line_nxt = 1'b0;
            S_DATA:   line_nxt = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: line_nxt = par_bit;
`endif
            default:  line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            uart_tx   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            uart_tx <= line_nxt;
            if (pop) begin
                state     <= S_START;
                baud_cnt  <= '0;
                bit_cnt   <= '0;
                shift_reg <= head;
`ifdef UART_TX_PARITY_EN
                par_bit   <= (^head) ^ parity_odd;
`endif
            end else if (state == S_IDLE) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_wrap ? '0 : baud_cnt + CW'(1);
                if (baud_wrap) begin
                    case (state)
                        S_START: begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                        S_DATA: begin
                            shift_reg <= shift_reg >> 1;
                            if (data_last) begin
                                bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                                state   <= S_PARITY;
`else
                                state   <= S_STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        S_PARITY: begin
                            state   <= S_STOP;
                            bit_cnt <= '0;
                        end
`endif
                        S_STOP: begin
                            if (stop_last) state <= S_IDLE;
                            else           bit_cnt <= bit_cnt + 3'd1;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench: three engine configurations, serial monitors decode each frame cycle by cycle.
`timescale 1ns/1ps
module tb_uart_tx_engine;
    localparam int DIV_A = 1250;
    localparam int DIV_B = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int WAIT_MAX = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic       rst_a, rst_b, rst_c;
    logic [7:0] dat_a, dat_b;
    logic [6:0] dat_c;
    logic       vld_a, vld_b, vld_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic       tx_a, tx_b, tx_c;
    logic       busy_a, busy_b, busy_c;
    logic [2:0] cnt_a, cnt_b, cnt_c;
    logic       podd;
    logic [2:0] mon_en;

    logic [8:0] q_a[$];
    logic [8:0] q_b[$];
    logic [8:0] q_c[$];
    int         gaps_b[$];

    uart_tx_engine u_a (
        .clk(clk), .reset(rst_a), .tx_data(dat_a), .tx_valid(vld_a), .tx_ready(rdy_a),
        .uart_tx(tx_a), .busy(busy_a), .fifo_count(cnt_a)
`ifdef UART_TX_PARITY_EN
        , .parity_odd(podd)
`endif
    );

    uart_tx_engine #(.BAUD(1500000)) u_b (
        .clk(clk), .reset(rst_b), .tx_data(dat_b), .tx_valid(vld_b), .tx_ready(rdy_b),
        .uart_tx(tx_b), .busy(busy_b), .fifo_count(cnt_b)
`ifdef UART_TX_PARITY_EN
        , .parity_odd(podd)
`endif
    );

    uart_tx_engine #(.BAUD(1500000), .DATA_BITS(7), .STOP_BITS(2)) u_c (
        .clk(clk), .reset(rst_c), .tx_data(dat_c), .tx_valid(vld_c), .tx_ready(rdy_c),
        .uart_tx(tx_c), .busy(busy_c), .fifo_count(cnt_c)
`ifdef UART_TX_PARITY_EN
        , .parity_odd(podd)
`endif
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic line_of(int w);
        case (w)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic rdy_of(int w);
        case (w)
            0:       return rdy_a;
            1:       return rdy_b;
            default: return rdy_c;
        endcase
    endfunction

    function automatic logic busy_of(int w);
        case (w)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic int qsize(int w);
        case (w)
            0:       return q_a.size();
            1:       return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    function automatic logic [8:0] qpop(int w);
        case (w)
            0:       return q_a.pop_front();
            1:       return q_b.pop_front();
            default: return q_c.pop_front();
        endcase
    endfunction

    function automatic void qpush(int w, logic [8:0] item);
        case (w)
            0:       q_a.push_back(item);
            1:       q_b.push_back(item);
            default: q_c.push_back(item);
        endcase
    endfunction

    task automatic set_drive(int w, logic v, logic [7:0] d);
        case (w)
            0:       begin vld_a = v; dat_a = d; end
            1:       begin vld_b = v; dat_b = d; end
            default: begin vld_c = v; dat_c = d[6:0]; end
        endcase
    endtask

    // Called on a negedge; returns on the negedge after the accepting posedge.
    task automatic push(int w, logic [7:0] d, bit score);
        int t = 0;
        set_drive(w, 1'b1, d);
        while (!rdy_of(w) && t < WAIT_MAX) begin
            @(negedge clk);
            t++;
        end
        check("push_wait_expired", t >= WAIT_MAX, 0);
        if (score) qpush(w, {podd, d});
        @(negedge clk);
        set_drive(w, 1'b0, 8'h00);
    endtask

    task automatic drain(int w);
        int t = 0;
        while ((busy_of(w) || qsize(w) != 0) && t < WAIT_MAX) begin
            @(negedge clk);
            t++;
        end
        check("drain_wait_expired", t >= WAIT_MAX, 0);
        repeat (4) @(negedge clk);
    endtask

    // Entered on the negedge of the first start-bit sample.
    task automatic run_frame(int w, string nm, int db, int sb, int div, logic [8:0] item);
        logic [15:0] bits;
        logic [7:0]  got;
        logic [7:0]  mask;
        logic        p;
        int          nb;
        int          mism;
        bits = '0;
        got  = '0;
        p    = item[8];
        nb   = 1;
        for (int i = 0; i < db; i++) begin
            bits[nb] = item[i];
            p ^= item[i];
            nb++;
        end
        if (PAR != 0) begin
            bits[nb] = p;
            nb++;
        end
        for (int i = 0; i < sb; i++) begin
            bits[nb] = 1'b1;
            nb++;
        end
        for (int b = 0; b < nb; b++) begin
            mism = 0;
            for (int k = 0; k < div; k++) begin
                if (b != 0 || k != 0) @(negedge clk);
                if (line_of(w) !== bits[b]) mism++;
                if (k == div / 2 && b >= 1 && b <= db) got[b-1] = line_of(w);
            end
            check($sformatf("%s_bit%0d_bad_cycles", nm, b), mism, 0);
        end
        mask = 8'((1 << db) - 1);
        check({nm, "_data"}, got, item[7:0] & mask);
    endtask

    task automatic monitor(int w, string nm, int db, int sb, int div);
        logic       prev;
        int         last_end;
        logic [8:0] item;
        prev     = 1'b1;
        last_end = -1000;
        forever begin
            @(negedge clk);
            if (mon_en[w] && prev && !line_of(w)) begin
                if (w == 1) gaps_b.push_back(cyc - last_end - 1);
                if (qsize(w) == 0) begin
                    check({nm, "_unexpected_frame"}, 1, 0);
                    item = '0;
                end else begin
                    item = qpop(w);
                end
                run_frame(w, nm, db, sb, div, item);
                last_end = cyc;
            end
            prev = line_of(w);
        end
    endtask

    initial monitor(0, "a", 8, 1, DIV_A);
    initial monitor(1, "b", 8, 1, DIV_B);
    initial monitor(2, "c", 7, 2, DIV_B);

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int trans;
        logic prev;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
        dat_a = '0; dat_b = '0; dat_c = '0;
        podd = 1'b0;
        mon_en = 3'b111;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(negedge clk);

        check("rst_uart_tx_a", tx_a, 1);
        check("rst_tx_ready_a", rdy_a, 1);
        check("rst_busy_a", busy_a, 0);
        check("rst_fifo_count_a", cnt_a, 0);
        check("rst_uart_tx_b", tx_b, 1);
        check("rst_busy_b", busy_b, 0);

        // Default configuration, single 0x77 frame.
        push(0, 8'h77, 1'b1);
        drain(0);
        check("a_idle_line", tx_a, 1);
        check("a_idle_busy", busy_a, 0);

        // Latency from acceptance to start bit.
        push(1, 8'h40, 1'b1);
        @(negedge clk);
        check("b_latency_n1_line", tx_b, 1);
        @(negedge clk);
        check("b_latency_n2_line", tx_b, 0);

        // Fill the FIFO while a frame is in flight.
        for (int i = 0; i < 4; i++) push(1, 8'(8'h41 + i), 1'b1);
        check("b_full_ready", rdy_b, 0);
        check("b_full_count", cnt_b, 4);

        // Fifth word held valid until space opens.
        set_drive(1, 1'b1, 8'h45);
        t = 0;
        while (!rdy_b && t < WAIT_MAX) begin
            @(negedge clk);
            t++;
        end
        check("b_ready_wait_expired", t >= WAIT_MAX, 0);
        check("b_ready_held_low_long", t > 40, 1);
        check("b_count_at_ready_rise", cnt_b, 3);
        qpush(1, {podd, 8'h45});
        @(negedge clk);
        check("b_fifth_accepted_count", cnt_b, 4);

        // Push held while full across a pop: must be dropped.
        set_drive(1, 1'b1, 8'h99);
        t = 0;
        while (cnt_b == 3'd4 && t < WAIT_MAX) begin
            @(negedge clk);
            t++;
        end
        set_drive(1, 1'b0, 8'h00);
        check("b_full_pop_wait_expired", t >= WAIT_MAX, 0);
        check("b_full_pop_count", cnt_b, 3);
        check("b_full_pop_ready", rdy_b, 1);
        drain(1);
        check("b_frames_seen", gaps_b.size(), 6);
        for (int i = 1; i < gaps_b.size(); i++)
            check($sformatf("b_gap_frame%0d", i), gaps_b[i], 0);
        check("b_drained_count", cnt_b, 0);

        // Reset in the middle of the data bits of 0x55, with 0x66 still queued.
        mon_en[1] = 1'b0;
        push(1, 8'h55, 1'b0);
        push(1, 8'h66, 1'b0);
        t = 0;
        while (tx_b && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("b_abort_start_expired", t >= 100, 0);
        repeat (DIV_B * 3 + 3) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        check("b_abort_line", tx_b, 1);
        check("b_abort_count", cnt_b, 0);
        check("b_abort_busy", busy_b, 0);
        check("b_abort_ready", rdy_b, 1);
        trans = 0;
        prev = tx_b;
        repeat (DIV_B * 30) begin
            @(negedge clk);
            if (tx_b !== prev) trans++;
            prev = tx_b;
        end
        check("b_abort_quiet_transitions", trans, 0);
        mon_en[1] = 1'b1;
        push(1, 8'h5A, 1'b1);
        drain(1);

        // A few more patterns.
        for (int i = 0; i < 3; i++) push(1, 8'($urandom_range(0, 255)), 1'b1);
        push(1, 8'h00, 1'b1);
        push(1, 8'hFF, 1'b1);
        drain(1);

        // Seven data bits, two stop bits.
        push(2, 8'h2A, 1'b1);
        drain(2);
        check("c_idle_line", tx_c, 1);
        check("c_idle_busy", busy_c, 0);

`ifdef UART_TX_PARITY_EN
        podd = 1'b0;
        push(1, 8'h07, 1'b1);
        drain(1);
        podd = 1'b1;
        push(1, 8'h07, 1'b1);
        drain(1);
        podd = 1'b0;
`endif

        check("a_queue_left", q_a.size(), 0);
        check("b_queue_left", q_b.size(), 0);
        check("c_queue_left", q_c.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
